// File: rtl/shift_deser_if.sv
// Serial-in / parallel-out bus for shift_deser: serial input side plus the
// valid/ready word output and status flags.
interface shift_deser_if #(parameter int W = 4);
    logic         sin;
    logic         sin_valid;
    logic         dir;
    logic [W-1:0] o;
    logic         o_valid;
    logic         o_ready;
    logic         overrun;
    logic         busy;
    logic         perr;

    modport master (
        output sin, sin_valid, dir, o_ready,
        input  o, o_valid, overrun, busy, perr
    );

    modport slave (
        input  sin, sin_valid, dir, o_ready,
        output o, o_valid, overrun, busy, perr
    );
endinterface

// File: rtl/shift_deser.sv
// Serial-in, parallel-out word receiver with a one-word valid/ready output register.
// Optional macro PARITY_EN: each word is followed by an even-parity bit.
module shift_deser #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic           clear,
    shift_deser_if.slave   bus
);
    localparam int CW = $clog2(W);

`ifdef PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t        state, state_n;
    logic [CW-1:0] count, count_n;
    logic [W-1:0]  sreg, sreg_n, shifted;
    logic          dir_lat, dir_n, use_dir;
    logic          done;
    logic [W-1:0]  o_q;
    logic          o_valid_q, overrun_q;
`ifdef PARITY_EN
    logic          perr_n, perr_q;
`endif

    // The direction input only matters on the first bit of a word.
    assign use_dir = (state == IDLE) ? bus.dir : dir_lat;
    assign shifted = use_dir ? {bus.sin, sreg[W-1:1]} : {sreg[W-2:0], bus.sin};

    always_comb begin
        state_n = state;
        count_n = count;
        sreg_n  = sreg;
        dir_n   = dir_lat;
        done    = 1'b0;
`ifdef PARITY_EN
        perr_n  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bus.sin_valid) begin
                    dir_n   = bus.dir;
                    sreg_n  = shifted;
                    count_n = CW'(1);
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.sin_valid) begin
                    sreg_n = shifted;
                    if (count == CW'(W - 1)) begin
                        count_n = '0;
`ifdef PARITY_EN
                        state_n = PARITY;
`else
                        done    = 1'b1;
                        state_n = IDLE;
`endif
                    end else begin
                        count_n = count + CW'(1);
                    end
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                if (bus.sin_valid) begin
                    state_n = IDLE;
                    if ((^sreg) ^ bus.sin) perr_n = 1'b1;
                    else                   done   = 1'b1;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            count     <= '0;
            sreg      <= '0;
            dir_lat   <= 1'b0;
            o_q       <= '0;
            o_valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            count     <= '0;
            sreg      <= '0;
            dir_lat   <= 1'b0;
            o_q       <= '0;
            o_valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            sreg    <= sreg_n;
            dir_lat <= dir_n;
            // A completion can replace a word being consumed this cycle; otherwise it is dropped.
            if (done) begin
                if (!o_valid_q || bus.o_ready) begin
                    o_q       <= sreg_n;
                    o_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (o_valid_q && bus.o_ready) begin
                o_valid_q <= 1'b0;
            end
        end
    end

`ifdef PARITY_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)      perr_q <= 1'b0;
        else if (clear) perr_q <= 1'b0;
        else            perr_q <= perr_n;
    end
    assign bus.perr = perr_q;
`else
    assign bus.perr = 1'b0;
`endif

    assign bus.o       = o_q;
    assign bus.o_valid = o_valid_q;
    assign bus.overrun = overrun_q;
    assign bus.busy    = (state != IDLE);
endmodule

// File: tb/tb_shift_deser.sv
// Randomized scoreboard bench for shift_deser against a bit-list reference model.
module tb_shift_deser;
    localparam int W = 4;
`ifdef PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic clear = 1'b0;

    shift_deser_if #(.W(W)) bus();
    shift_deser #(.W(W)) dut (.clk(clk), .nrst(nrst), .clear(clear), .bus(bus));

    always #5 clk = ~clk;

    // Reference model: arrival-ordered bit list; m_* = state after the next edge,
    // c_* = state currently visible on the DUT outputs.
    bit           mb[$];
    logic         m_lat;
    logic [W-1:0] m_o, c_o;
    logic         m_v, c_v, m_ovr, c_ovr, m_busy, c_busy, m_perr, c_perr;
    logic [W-1:0] exp_q[$];

    int  passed = 0;
    int  total = 0;
    bit  run = 0;
    bit  done = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        mb.delete();
        exp_q.delete();
        m_lat = 0; m_o = '0; m_v = 0; m_ovr = 0; m_busy = 0; m_perr = 0;
        c_o = '0; c_v = 0; c_ovr = 0; c_busy = 0; c_perr = 0;
    endtask

    task automatic step(input logic clr, input logic sv, input logic s, input logic d, input logic rdy);
        logic         cmp;
        logic         par_ok;
        logic [W-1:0] w;
        int           x;
        @(posedge clk); #1;
        clear = clr; bus.sin_valid = sv; bus.sin = s; bus.dir = d; bus.o_ready = rdy;
        c_o = m_o; c_v = m_v; c_ovr = m_ovr; c_busy = m_busy; c_perr = m_perr;
        cmp = 0; w = '0; m_perr = 0;
        if (clr) begin
            mb.delete(); exp_q.delete();
            m_lat = 0; m_o = '0; m_v = 0; m_ovr = 0; m_busy = 0;
            return;
        end
        if (sv) begin
            if (mb.size() == 0) m_lat = d;
            mb.push_back(s);
            if (mb.size() == NB) begin
                for (int i = 0; i < W; i++) begin
                    if (m_lat) w = w | (W'(mb[i]) << i);
                    else       w = (w << 1) | W'(mb[i]);
                end
                x = 0;
                for (int i = 0; i < NB; i++) x = x ^ int'(mb[i]);
                par_ok = 1;
`ifdef PARITY_EN
                par_ok = (x == 0);
`endif
                if (par_ok) cmp = 1;
                else        m_perr = 1;
                mb.delete();
            end
        end
        if (cmp) begin
            if (!m_v || rdy) begin
                m_o = w; m_v = 1; exp_q.push_back(w);
            end else begin
                m_ovr = 1;
            end
        end else if (m_v && rdy) begin
            m_v = 0;
        end
        m_busy = (mb.size() != 0);
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1;
        clear = 0; bus.sin_valid = 0; bus.o_ready = 0;
        nrst = 0;
        #2;
        nrst = 1;
        model_reset();
    endtask

    // Sends v MSB-first in time; d0 on the first bit, d1 afterwards; ready only on the last bit.
    task automatic send_bits(input logic [W-1:0] v, input logic d0, input logic d1,
                             input logic rdy_last, input logic par_good);
        for (int i = 0; i < NB; i++) begin
            logic b;
            if (i < W) b = v[W-1-i];
            else       b = (^v) ^ !par_good;
            step(1'b0, 1'b1, b, (i == 0) ? d0 : d1, (i == NB - 1) ? rdy_last : 1'b0);
        end
    endtask

    // Monitor: per-cycle flag checks and scoreboard pop on every transfer.
    initial begin
        wait (run);
        while (!done) begin
            @(negedge clk);
            if (done) break;
            chk("o_valid", int'(bus.o_valid), int'(c_v));
            chk("o", int'(bus.o), int'(c_o));
            chk("overrun", int'(bus.overrun), int'(c_ovr));
            chk("busy", int'(bus.busy), int'(c_busy));
            chk("perr", int'(bus.perr), int'(c_perr));
            if (bus.o_valid && bus.o_ready && !clear) begin
                if (exp_q.size() == 0) chk("sb_unexpected_xfer", 1, 0);
                else                   chk("sb_word", int'(bus.o), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int r;
        bus.sin = 0; bus.sin_valid = 0; bus.dir = 0; bus.o_ready = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 nrst = 1;
        #1;
        chk("rst_o", int'(bus.o), 0);
        chk("rst_o_valid", int'(bus.o_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_overrun", int'(bus.overrun), 0);
        chk("rst_perr", int'(bus.perr), 0);
        run = 1;

        send_bits(4'b1011, 1'b0, 1'b0, 1'b0, 1'b1);
        step(0, 0, 0, 0, 0);
        chk("msb_first", int'(bus.o), 11);
        chk("msb_first_valid", int'(bus.o_valid), 1);
        step(0, 0, 0, 0, 1);

        send_bits(4'b1011, 1'b1, 1'b0, 1'b0, 1'b1);
        step(0, 0, 0, 0, 0);
        chk("lsb_first_dir_latched", int'(bus.o), 13);
        step(0, 0, 0, 0, 1);

        send_bits(4'b1010, 1'b0, 1'b0, 1'b0, 1'b1);
        send_bits(4'b0110, 1'b0, 1'b0, 1'b0, 1'b1);
        step(0, 0, 0, 0, 0);
        chk("overrun_keeps_old", int'(bus.o), 10);
        chk("overrun_set", int'(bus.overrun), 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("overrun_sticky", int'(bus.overrun), 1);
        chk("drained_valid", int'(bus.o_valid), 0);
        step(1, 0, 0, 0, 0);

        send_bits(4'b1010, 1'b0, 1'b0, 1'b0, 1'b1);
        send_bits(4'b0110, 1'b0, 1'b0, 1'b1, 1'b1);
        step(0, 0, 0, 0, 0);
        chk("no_bubble_word", int'(bus.o), 6);
        chk("no_bubble_valid", int'(bus.o_valid), 1);
        chk("no_bubble_overrun", int'(bus.overrun), 0);
        step(0, 0, 0, 0, 1);

        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        reset_pulse();
        send_bits(4'b0001, 1'b0, 1'b0, 1'b1, 1'b1);
        step(0, 0, 0, 0, 0);
        chk("after_midword_reset", int'(bus.o), 1);
        step(0, 0, 0, 0, 1);

        step(1, 1, 1, 0, 0);
        send_bits(4'b0110, 1'b0, 1'b0, 1'b0, 1'b1);
        step(0, 0, 0, 0, 0);
        chk("clear_ignores_bit", int'(bus.o), 6);
        step(0, 0, 0, 0, 1);

`ifdef PARITY_EN
        send_bits(4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
        step(0, 0, 0, 0, 0);
        chk("perr_pulse", int'(bus.perr), 1);
        chk("perr_no_word", int'(bus.o_valid), 0);
        step(0, 0, 0, 0, 0);
        chk("perr_one_cycle", int'(bus.perr), 0);
`endif

        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 999));
            if (r < 3) reset_pulse();
            else step(1'(r < 8), 1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (4) step(0, 0, 0, 0, 1);
        @(negedge clk);
        done = 1;
        chk("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/shift_deser.md
Name: shift_deser

Overview:
- Serial-in, parallel-out receiver. It rebuilds W-bit words from a 1-bit stream that was produced by shifting a word out left (MSB first) or right (LSB first).
- It is the receiving end of the team's one-bit logic shifters. Assembled words are handed to downstream logic over a valid/ready output.
- Holds one assembled word in an output register while the next word shifts in.

Parameters:
- W, 4, word width in bits (W >= 2).

Ports:
- clk  in  1  single clock, rising edge.
- nrst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush of all state; has priority over every other input.
- sin  in  1  serial data bit.
- sin_valid  in  1  sin is presented this cycle; always accepted (no backpressure on the input).
- dir  in  1  0 = MSB first (left shift into bit 0); 1 = LSB first (right shift into bit W-1).
- o  out  W  assembled word.
- o_valid  out  1  o holds an unconsumed word.
- o_ready  in  1  downstream takes o when o_valid && o_ready.
- overrun  out  1  sticky flag: a completed word was dropped.
- busy  out  1  a word is partially received (state SHIFT).
- perr  out  1  one-cycle parity-error pulse (only with PARITY_EN; tied 0 otherwise).

Behaviour:
- Reset (nrst=0, async) and clear=1 (sync) both force:
  - state = IDLE, count = 0, sreg = 0, dir_lat = 0;
  - o = 0, o_valid = 0, overrun = 0, busy = 0, perr = 0.
- Reset mid-word discards the partial word; there is no recovery.
- Internal state: sreg[W-1:0], count in 0..W-1, dir_lat.
- FSM states:
  - IDLE: count = 0, busy = 0. On sin_valid:
    - latch dir_lat = dir;
    - shift sin into sreg;
    - count = 1;
    - go to SHIFT.
  - SHIFT: busy = 1. dir is ignored here; dir_lat holds for the whole word. On each sin_valid:
    - shift using dir_lat;
    - count + 1.
  - When the W-th bit is accepted (count == W-1): word complete, count = 0, go to IDLE.
- Shift rule (logic shift, no bit lost inside a word):
  - dir_lat = 0: sreg_next = {sreg[W-2:0], sin}.
  - dir_lat = 1: sreg_next = {sin, sreg[W-1:1]}.
- Word completion: the completed word is the value sreg_next on the cycle the last bit is accepted.
  - Latency: o and o_valid update on the clock edge that accepts the W-th bit, so they are visible in the following cycle.
- Output handshake:
  - o_valid stays high and o stays stable until o_valid && o_ready.
  - A transfer without a new completion in the same cycle: o_valid goes to 0 next cycle; o holds its old value.
  - Completion while o_valid = 0: load o, set o_valid = 1.
  - Completion while o_valid = 1 and o_ready = 1 in the same cycle: load the new word, o_valid stays 1. No bubble, no overrun.
  - Completion while o_valid = 1 and o_ready = 0: the new word is dropped, o keeps the old word, overrun = 1. overrun is sticky until clear or reset.
- W=2 boundary: IDLE → SHIFT → complete. A single-bit word is never possible.
- sin_valid gaps of any length inside a word are allowed; state and count are held.

Optional Feature:
- Macro PARITY_EN.
- Defined:
  - Each word is followed by one extra even-parity bit. The FSM gains state PARITY, entered after the W-th data bit; no completion happens yet.
  - The next accepted sin is the parity bit. Word completes only if XOR(data bits, parity bit) == 0; then the normal handshake/overrun rules apply.
  - On mismatch: word discarded, o/o_valid unchanged, perr = 1 for exactly one cycle, overrun not affected.
  - busy = 1 in PARITY. State returns to IDLE either way.
- Not defined:
  - No PARITY state, words are exactly W bits, perr is constant 0.

Test Plan:
- W=4, dir=0, sin_valid each cycle, bits 1,0,1,1 → o=4'b1011, o_valid rises 1 cycle after the 4th bit, busy high for bits 2–4.
- W=4, dir=1, bits 1,0,1,1 → o=4'b1101. dir toggled to 0 after bit 1 → still 4'b1101 (dir latched).
- o_ready=0; send 4'b1010 then 4'b0110 → o stays 4'b1010, overrun=1. Then assert o_ready: o_valid drops, overrun stays 1 until clear.
- o_ready=1 on the exact cycle the next word completes → o changes 4'b1010→4'b0110, o_valid never drops, overrun=0.
- Send bits 1,1, pull nrst low asynchronously mid-cycle, release, send 0,0,0,1 (dir=0) → o=4'b0001, no remnant of the aborted word. Also: clear in the same cycle as sin_valid → bit ignored, count=0.
- PARITY_EN, dir=0: data 1,0,1,1 + parity 1 → o=4'b1011. Same data + parity 0 → perr one-cycle pulse, o_valid unchanged.
